// File: rtl/regfile_ctrl.sv
`default_nettype none
// ============================================================================
// regfile_ctrl -- 16x16 register file sequencing one ALU instruction per 3 cycles
// Rev 1.0
// ============================================================================
module regfile_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [4:0]  instr_op,
  input  logic [3:0]  instr_rdest,
  input  logic [3:0]  instr_rsrc,
  input  logic [7:0]  instr_imm,
  input  logic        instr_use_imm,
  input  logic        instr_imm_signed,
  output logic [15:0] alu_rdest,
  output logic [15:0] alu_rsrc,
  output logic [4:0]  alu_opcode,
  input  logic [15:0] alu_out,
  input  logic [4:0]  alu_flags,
  output logic [4:0]  psr,
  output logic        done,
  output logic        err,
  input  logic [3:0]  rd_addr,
  output logic [15:0] rd_data
);

  localparam int         DATA_W    = 16;
  localparam int         NUM_REGS  = 16;
  localparam logic [4:0] C_OP_CMP  = 5'd2;
  localparam logic [4:0] C_OP_LAST = 5'd9;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [4:0]          op_q;
  logic [3:0]          rdest_q;
  logic [DATA_W-1:0]   opa_q;
  logic [DATA_W-1:0]   opb_q;
  logic [4:0]          psr_q;

  logic                w_ready;
  logic                w_accept;
  logic                w_retire;
  logic                w_illegal;
  logic                w_wr_en;
  logic                w_psr_en;
  logic [DATA_W-1:0]   w_imm_ext;
  logic [DATA_W-1:0]   w_src;

  always_comb begin
    state_d  = state_q;
    w_ready  = 1'b0;
    w_accept = 1'b0;
    w_retire = 1'b0;
    case (state_q)
      S_IDLE: begin
        w_ready = !reset;
        if (instr_valid && w_ready) begin
          w_accept = 1'b1;
          state_d  = S_EXEC;
        end
      end
      S_EXEC: state_d = S_WB;
      S_WB: begin
        // Reset in WB aborts the instruction, so retirement is gated here.
        w_retire = !reset;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    w_imm_ext = instr_imm_signed ? {{8{instr_imm[7]}}, instr_imm} : {8'h00, instr_imm};
    w_src     = instr_use_imm ? w_imm_ext : regs_q[instr_rsrc];
    w_illegal = (op_q > C_OP_LAST);
    w_wr_en   = w_retire && !w_illegal && (op_q != C_OP_CMP);
    w_psr_en  = w_retire && (op_q <= C_OP_CMP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      rdest_q <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      psr_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (w_accept) begin
        op_q    <= instr_op;
        rdest_q <= instr_rdest;
        opa_q   <= regs_q[instr_rdest];
        opb_q   <= w_src;
      end
      if (w_wr_en) begin
        regs_q[rdest_q] <= alu_out;
      end
      if (w_psr_en) begin
        psr_q <= alu_flags;
      end
    end
  end

  assign instr_ready = w_ready;
  assign alu_rdest   = opa_q;
  assign alu_rsrc    = opb_q;
  assign alu_opcode  = op_q;
  assign psr         = psr_q;
  assign done        = w_retire;
  assign err         = w_retire && w_illegal;
  assign rd_data     = regs_q[rd_addr];

endmodule
`default_nettype wire
